// File: rtl/vdata_access_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vdata_access_pkg : shared types and constants for vdata_access_ctrl        |
// | Revision : 1.0                                                             |
// +--------------------------------------------------------------------------+
package vdata_access_pkg;

  localparam int unsigned VDAC_ADDR_W    = 32;
  localparam int unsigned VDAC_DATA_W    = 256;
  localparam int unsigned VDAC_BLOCK_W   = 256;
  localparam int unsigned VDAC_MICROOP_W = 7;
  localparam int unsigned VDAC_SIZE_W    = 6;
  localparam int unsigned BLOCK_BYTES    = VDAC_BLOCK_W / 8;
  localparam int unsigned VDAC_OFF_W     = $clog2(BLOCK_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD0  = 3'd1,
    ST_RD1  = 3'd2,
    ST_OP   = 3'd3,
    ST_WR0  = 3'd4,
    ST_WR1  = 3'd5,
    ST_RESP = 3'd6
  } vdac_state_e;

  typedef struct packed {
    logic [VDAC_ADDR_W-1:0]    addr;
    logic                      is_store;
    logic [VDAC_MICROOP_W-1:0] microop;
    logic [VDAC_SIZE_W-1:0]    size;
    logic [VDAC_DATA_W-1:0]    data;
  } vdac_req_t;

endpackage
`default_nettype wire

// File: rtl/vdata_span_calc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vdata_span_calc : block addresses and boundary-straddle flag of a request  |
// | Revision : 1.0                                                             |
// +--------------------------------------------------------------------------+
module vdata_span_calc #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned SIZE_W      = 6,
  parameter int unsigned OFF_W       = 5,
  parameter int unsigned BLOCK_BYTES = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [SIZE_W-1:0] size_i,
  output logic [ADDR_W-1:0] blk0_o,
  output logic [ADDR_W-1:0] blk1_o,
  output logic              span_o
);

  localparam int unsigned SUM_W = OFF_W + SIZE_W + 1;

  logic [SUM_W-1:0] w_end;

  // Sum is kept at full width so offset+size can never wrap.
  assign w_end  = SUM_W'(addr_i[OFF_W-1:0]) + SUM_W'(size_i);
  assign span_o = (w_end > SUM_W'(BLOCK_BYTES));
  assign blk0_o = {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign blk1_o = blk0_o + ADDR_W'(BLOCK_BYTES);

endmodule
`default_nettype wire

// File: rtl/vdata_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vdata_access_ctrl : splits vector ld/st into block-aligned cache accesses  |
// | Optional: VDATA_ACCESS_PERF_EN adds saturating performance counters.       |
// | Revision : 1.0                                                             |
// +--------------------------------------------------------------------------+
module vdata_access_ctrl
  import vdata_access_pkg::*;
#(
  parameter int unsigned ADDR_W    = VDAC_ADDR_W,
  parameter int unsigned DATA_W    = VDAC_DATA_W,
  parameter int unsigned BLOCK_W   = VDAC_BLOCK_W,
  parameter int unsigned MICROOP_W = VDAC_MICROOP_W,
  parameter int unsigned SIZE_W    = VDAC_SIZE_W,
  parameter int unsigned OFF_W     = $clog2(BLOCK_W/8)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic                  req_is_store_i,
  input  logic [MICROOP_W-1:0]  req_microop_i,
  input  logic [SIZE_W-1:0]     req_size_i,
  input  logic [DATA_W-1:0]     req_data_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_W-1:0]     mem_req_addr_o,
  output logic                  mem_req_we_o,
  output logic [BLOCK_W-1:0]    mem_wdata_o,
  input  logic                  mem_resp_valid_i,
  input  logic [BLOCK_W-1:0]    mem_rdata_i,
  output logic                  dop_valid_o,
  output logic [OFF_W-1:0]      dop_offset_o,
  output logic [2*BLOCK_W-1:0]  dop_block_o,
  output logic [DATA_W-1:0]     dop_data_o,
  output logic                  dop_multi_o,
  output logic [MICROOP_W-1:0]  dop_microop_o,
  output logic [SIZE_W-1:0]     dop_size_o,
  input  logic [DATA_W-1:0]     dop_vector_i,
  input  logic [2*BLOCK_W-1:0]  dop_block_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_W-1:0]     resp_data_o,
  output logic [31:0]           perf_req_cnt_o,
  output logic [31:0]           perf_split_cnt_o,
  output logic [31:0]           perf_stall_cnt_o
);

  vdac_state_e              state_q;
  vdac_req_t                req_q;
  logic [2*BLOCK_W-1:0]     window_q;
  logic                     req_ready_q;
  logic                     mem_req_valid_q;
  logic                     mem_req_we_q;
  logic [ADDR_W-1:0]        mem_req_addr_q;
  logic [BLOCK_W-1:0]       mem_wdata_q;
  logic                     dop_valid_q;
  logic                     resp_valid_q;
  logic [DATA_W-1:0]        resp_data_q;

  logic [ADDR_W-1:0]        w_calc_addr;
  logic [SIZE_W-1:0]        w_calc_size;
  logic [ADDR_W-1:0]        w_blk0;
  logic [ADDR_W-1:0]        w_blk1;
  logic                     w_span;

  // In IDLE the calculator looks at the incoming request so the first cache
  // address can be registered on the accept edge; afterwards at the latched one.
  assign w_calc_addr = (state_q == ST_IDLE) ? req_addr_i : req_q.addr;
  assign w_calc_size = (state_q == ST_IDLE) ? req_size_i : req_q.size;

  vdata_span_calc #(
    .ADDR_W      (ADDR_W),
    .SIZE_W      (SIZE_W),
    .OFF_W       (OFF_W),
    .BLOCK_BYTES (BLOCK_W/8)
  ) u_span_calc (
    .addr_i (w_calc_addr),
    .size_i (w_calc_size),
    .blk0_o (w_blk0),
    .blk1_o (w_blk1),
    .span_o (w_span)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      req_q           <= '0;
      window_q        <= '0;
      req_ready_q     <= 1'b1;
      mem_req_valid_q <= 1'b0;
      mem_req_we_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_wdata_q     <= '0;
      dop_valid_q     <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid_i && req_ready_q) begin
            req_ready_q <= 1'b0;
            req_q       <= '{addr: req_addr_i, is_store: req_is_store_i,
                             microop: req_microop_i, size: req_size_i,
                             data: req_data_i};
            if (req_size_i == '0) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_data_q  <= '0;
            end else begin
              state_q         <= ST_RD0;
              mem_req_valid_q <= 1'b1;
              mem_req_we_q    <= 1'b0;
              mem_req_addr_q  <= w_blk0;
            end
          end
        end
        ST_RD0, ST_RD1: begin
          if (mem_req_valid_q) begin
            if (mem_req_ready_i) mem_req_valid_q <= 1'b0;
          end else if (mem_resp_valid_i) begin
            if (state_q == ST_RD0) begin
              window_q <= {{BLOCK_W{1'b0}}, mem_rdata_i};
              if (w_span) begin
                state_q         <= ST_RD1;
                mem_req_valid_q <= 1'b1;
                mem_req_addr_q  <= w_blk1;
              end else begin
                state_q     <= ST_OP;
                dop_valid_q <= 1'b1;
              end
            end else begin
              window_q[2*BLOCK_W-1:BLOCK_W] <= mem_rdata_i;
              state_q     <= ST_OP;
              dop_valid_q <= 1'b1;
            end
          end
        end
        ST_OP: begin
          dop_valid_q <= 1'b0;
          if (req_q.is_store) begin
            window_q        <= dop_block_i;
            state_q         <= ST_WR0;
            mem_req_valid_q <= 1'b1;
            mem_req_we_q    <= 1'b1;
            mem_req_addr_q  <= w_blk0;
            mem_wdata_q     <= dop_block_i[BLOCK_W-1:0];
          end else begin
            resp_data_q  <= dop_vector_i;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end
        end
        ST_WR0, ST_WR1: begin
          if (mem_req_ready_i) begin
            if ((state_q == ST_WR0) && w_span) begin
              state_q        <= ST_WR1;
              mem_req_addr_q <= w_blk1;
              mem_wdata_q    <= window_q[2*BLOCK_W-1:BLOCK_W];
            end else begin
              mem_req_valid_q <= 1'b0;
              mem_req_we_q    <= 1'b0;
              state_q         <= ST_RESP;
              resp_valid_q    <= 1'b1;
              resp_data_q     <= '0;
            end
          end
        end
        ST_RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o     = req_ready_q;
  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_req_we_o    = mem_req_we_q;
  assign mem_req_addr_o  = mem_req_addr_q;
  assign mem_wdata_o     = mem_wdata_q;
  assign dop_valid_o     = dop_valid_q;
  assign dop_offset_o    = req_q.addr[OFF_W-1:0];
  assign dop_block_o     = window_q;
  assign dop_data_o      = req_q.data;
  assign dop_multi_o     = w_span;
  assign dop_microop_o   = req_q.microop;
  assign dop_size_o      = req_q.size;
  assign resp_valid_o    = resp_valid_q;
  assign resp_data_o     = resp_data_q;

`ifdef VDATA_ACCESS_PERF_EN
  logic [31:0] perf_req_q;
  logic [31:0] perf_split_q;
  logic [31:0] perf_stall_q;
  logic        w_accept;

  assign w_accept = (state_q == ST_IDLE) && req_valid_i && req_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_req_q   <= '0;
      perf_split_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (w_accept && (perf_req_q != '1)) perf_req_q <= perf_req_q + 32'd1;
      if (w_accept && w_span && (perf_split_q != '1)) perf_split_q <= perf_split_q + 32'd1;
      if (mem_req_valid_q && !mem_req_ready_i && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_req_cnt_o   = perf_req_q;
  assign perf_split_cnt_o = perf_split_q;
  assign perf_stall_cnt_o = perf_stall_q;
`else
  assign perf_req_cnt_o   = '0;
  assign perf_split_cnt_o = '0;
  assign perf_stall_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vdata_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vdata_access_ctrl : scoreboard bench with byte-level cache model        |
// | Revision : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_vdata_access_ctrl;

  logic          clk;
  logic          rst_n;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [31:0]   req_addr_i;
  logic          req_is_store_i;
  logic [6:0]    req_microop_i;
  logic [5:0]    req_size_i;
  logic [255:0]  req_data_i;
  logic          mem_req_valid_o;
  logic          mem_req_ready_i;
  logic [31:0]   mem_req_addr_o;
  logic          mem_req_we_o;
  logic [255:0]  mem_wdata_o;
  logic          mem_resp_valid_i;
  logic [255:0]  mem_rdata_i;
  logic          dop_valid_o;
  logic [4:0]    dop_offset_o;
  logic [511:0]  dop_block_o;
  logic [255:0]  dop_data_o;
  logic          dop_multi_o;
  logic [6:0]    dop_microop_o;
  logic [5:0]    dop_size_o;
  logic [255:0]  dop_vector_i;
  logic [511:0]  dop_block_i;
  logic          resp_valid_o;
  logic          resp_ready_i;
  logic [255:0]  resp_data_o;
  logic [31:0]   perf_req_cnt_o;
  logic [31:0]   perf_split_cnt_o;
  logic [31:0]   perf_stall_cnt_o;

  vdata_access_ctrl u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_addr_i       (req_addr_i),
    .req_is_store_i   (req_is_store_i),
    .req_microop_i    (req_microop_i),
    .req_size_i       (req_size_i),
    .req_data_i       (req_data_i),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_req_we_o     (mem_req_we_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_rdata_i      (mem_rdata_i),
    .dop_valid_o      (dop_valid_o),
    .dop_offset_o     (dop_offset_o),
    .dop_block_o      (dop_block_o),
    .dop_data_o       (dop_data_o),
    .dop_multi_o      (dop_multi_o),
    .dop_microop_o    (dop_microop_o),
    .dop_size_o       (dop_size_o),
    .dop_vector_i     (dop_vector_i),
    .dop_block_i      (dop_block_i),
    .resp_valid_o     (resp_valid_o),
    .resp_ready_i     (resp_ready_i),
    .resp_data_o      (resp_data_o),
    .perf_req_cnt_o   (perf_req_cnt_o),
    .perf_split_cnt_o (perf_split_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
  );

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } mexp_t;

  typedef struct {
    logic [4:0] off;
    logic       multi;
    logic [6:0] mop;
    logic [5:0] sz;
  } oexp_t;

  mexp_t        mq[$];
  oexp_t        opq[$];
  logic [255:0] rq[$];
  logic [7:0]   mem[logic [31:0]];

  int n_chk = 0;
  int n_err = 0;
  int n_resp = 0;
  int n_acc = 0;
  int cyc = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: cache never ready

  logic        pend = 1'b0;
  int          pend_dly = 0;
  logic [31:0] pend_addr = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // External vdata_operation: extract/insert size bytes at offset in the window.
  always_comb begin
    dop_vector_i = '0;
    dop_block_i  = dop_block_o;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(dop_size_o)) begin
        dop_vector_i[i*8 +: 8] = dop_block_o[(int'(dop_offset_o) + i)*8 +: 8];
        dop_block_i[(int'(dop_offset_o) + i)*8 +: 8] = dop_data_o[i*8 +: 8];
      end
    end
  end

  // Cache responder plus response-side ready.
  initial begin
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_rdata_i      = '0;
    resp_ready_i     = 1'b0;
    forever begin
      @(posedge clk); #1;
      mem_resp_valid_i = 1'b0;
      if (!rst_n) pend = 1'b0;
      if (pend) begin
        pend_dly--;
        if (pend_dly == 0) begin
          pend = 1'b0;
          mem_resp_valid_i = 1'b1;
          for (int j = 0; j < 32; j++) mem_rdata_i[j*8 +: 8] = rd_byte(pend_addr + 32'(j));
        end
      end
      case (ready_mode)
        0:       mem_req_ready_i = 1'b1;
        1:       mem_req_ready_i = 1'($urandom_range(0, 1));
        default: mem_req_ready_i = 1'b0;
      endcase
      resp_ready_i = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (rst_n && mem_req_valid_o && mem_req_ready_i && !mem_req_we_o) begin
        pend      = 1'b1;
        pend_dly  = (ready_mode == 1) ? $urandom_range(1, 3) : 1;
        pend_addr = mem_req_addr_o;
      end
    end
  end

  // Monitor: scoreboard pops and backpressure stability.
  initial begin
    logic         p_mv, p_mr, p_we, p_rv, p_rr;
    logic [31:0]  p_addr;
    logic [255:0] p_wd, p_rd;
    mexp_t        e;
    oexp_t        o;
    logic [255:0] r;
    p_mv = 0; p_mr = 0; p_we = 0; p_rv = 0; p_rr = 0; p_addr = '0; p_wd = '0; p_rd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_mv = 0;
        p_rv = 0;
      end else begin
        if (p_mv && !p_mr)
          chk("mem_hold", {mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_wdata_o},
              {1'b1, p_we, p_addr, p_wd});
        if (mem_req_valid_o && mem_req_ready_i) begin
          chk("mem_align", mem_req_addr_o[4:0], 5'd0);
          if (mq.size() == 0) begin
            chk("mem_unexp", mem_req_valid_o & mem_req_ready_i, 1'b0);
          end else begin
            e = mq.pop_front();
            chk("mem_we", mem_req_we_o, e.we);
            chk("mem_addr", mem_req_addr_o, e.addr);
            if (e.we) begin
              chk("mem_wdata", mem_wdata_o, e.wdata);
              for (int j = 0; j < 32; j++) mem[e.addr + 32'(j)] = e.wdata[j*8 +: 8];
            end
          end
        end
        if (dop_valid_o) begin
          if (opq.size() == 0) begin
            chk("op_unexp", dop_valid_o, 1'b0);
          end else begin
            o = opq.pop_front();
            chk("dop_offset", dop_offset_o, o.off);
            chk("dop_multi", dop_multi_o, o.multi);
            chk("dop_microop", dop_microop_o, o.mop);
            chk("dop_size", dop_size_o, o.sz);
          end
        end
        if (resp_valid_o) begin
          if (p_rv && !p_rr) chk("resp_hold", resp_data_o, p_rd);
          if (resp_ready_i) begin
            if (rq.size() == 0) begin
              chk("resp_unexp", resp_valid_o, 1'b0);
            end else begin
              r = rq.pop_front();
              chk("resp_data", resp_data_o, r);
            end
            n_resp++;
          end
        end
        p_mv = mem_req_valid_o; p_mr = mem_req_ready_i; p_we = mem_req_we_o;
        p_addr = mem_req_addr_o; p_wd = mem_wdata_o;
        p_rv = resp_valid_o; p_rr = resp_ready_i; p_rd = resp_data_o;
      end
    end
  end

  task automatic drive_req(input logic [31:0] a, input logic st, input int sz,
                           input logic [255:0] d, input logic [6:0] mop, output int t0);
    logic ok;
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_addr_i = a; req_is_store_i = st;
    req_size_i = 6'(sz); req_data_i = d; req_microop_i = mop;
    ok = 1'b0;
    t0 = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (req_ready_o) begin
        ok = 1'b1;
        t0 = cyc;
      end
    end
    chk("accept", req_ready_o, 1'b1);
    if (ok) n_acc++;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] a, input logic st, input int sz,
                        input logic [255:0] d, input logic [6:0] mop, input int exp_lat);
    logic [31:0]  b0;
    int           off, t0, tr, n0;
    logic         sp;
    mexp_t        m;
    oexp_t        o;
    logic [255:0] r;
    logic [511:0] win;
    off = int'(a[4:0]);
    sp  = (off + sz) > 32;
    b0  = {a[31:5], 5'b0};
    if (sz != 0) begin
      m.we = 1'b0; m.wdata = '0;
      m.addr = b0;         mq.push_back(m);
      if (sp) begin m.addr = b0 + 32'd32; mq.push_back(m); end
      o.off = a[4:0]; o.multi = sp; o.mop = mop; o.sz = 6'(sz);
      opq.push_back(o);
    end
    r = '0;
    if (!st) for (int i = 0; i < sz; i++) r[i*8 +: 8] = rd_byte(a + 32'(i));
    rq.push_back(r);
    if (st && sz != 0) begin
      for (int j = 0; j < 64; j++) win[j*8 +: 8] = rd_byte(b0 + 32'(j));
      for (int i = 0; i < sz; i++) win[(off + i)*8 +: 8] = d[i*8 +: 8];
      m.we = 1'b1;
      m.addr = b0; m.wdata = win[255:0]; mq.push_back(m);
      if (sp) begin m.addr = b0 + 32'd32; m.wdata = win[511:256]; mq.push_back(m); end
    end
    n0 = n_resp;
    drive_req(a, st, sz, d, mop, t0);
    tr = -1;
    for (int k = 0; k < 400 && n_resp == n0; k++) begin
      @(negedge clk);
      if (resp_valid_o && tr < 0) tr = cyc;
    end
    chk("resp_done", resp_valid_o | (n_resp != n0), 1'b1);
    if (exp_lat > 0) chk("latency", 32'(tr - t0), 32'(exp_lat));
    chk("mq_left", 32'(mq.size()), 32'd0);
    chk("opq_left", 32'(opq.size()), 32'd0);
  endtask

  initial begin
    int          t0;
    logic        found;
    mexp_t       m;
    logic [31:0] a;
    int          sz;
    rst_n = 1'b0;
    req_valid_i = 1'b0; req_addr_i = '0; req_is_store_i = 1'b0;
    req_microop_i = '0; req_size_i = '0; req_data_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready_o, 1'b1);
    chk("rst_outputs", {mem_req_valid_o, dop_valid_o, resp_valid_o, mem_req_we_o}, 4'b0);
    chk("rst_resp_data", resp_data_o, 256'd0);
    #2 rst_n = 1'b1;

    ready_mode = 0;
    do_req(32'h0000_0100, 1'b0, 32, '0, 7'h11, 4);
    do_req(32'h0000_011C, 1'b0, 16, '0, 7'h22, 6);
    do_req(32'h0000_00F8, 1'b1, 32, rand256(), 7'h33, 0);
    do_req(32'h0000_00F8, 1'b0, 32, '0, 7'h44, 0);
    do_req(32'hFFFF_FFF0, 1'b0, 32, '0, 7'h55, 0);
    do_req(32'h0000_0140, 1'b0, 0, '0, 7'h66, 1);

    // Reset while the second read of a straddling load is stalled.
    m.we = 1'b0; m.wdata = '0; m.addr = 32'h0000_0100; mq.push_back(m);
    drive_req(32'h0000_011C, 1'b0, 16, '0, 7'h77, t0);
    for (int k = 0; k < 50 && mq.size() != 0; k++) @(negedge clk);
    ready_mode = 2;
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (mem_req_valid_o && mem_req_addr_o == 32'h0000_0120) found = 1'b1;
    end
    chk("rd1_stalled", {mem_req_valid_o, mem_req_addr_o}, {1'b1, 32'h0000_0120});
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_valid", mem_req_valid_o, 1'b0);
    chk("midrst_req_ready", req_ready_o, 1'b1);
    chk("midrst_dop_resp", {dop_valid_o, resp_valid_o}, 2'b00);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    n_acc = 0;
    ready_mode = 0;
    repeat (3) @(negedge clk);
    chk("midrst_no_write", {mem_req_valid_o, 32'(mq.size())}, 33'd0);
    do_req(32'h0000_011C, 1'b0, 16, '0, 7'h08, 6);

    ready_mode = 1;
    do_req(32'h0000_0100, 1'b0, 32, '0, 7'h11, 0);
    do_req(32'h0000_011C, 1'b0, 16, '0, 7'h22, 0);
    do_req(32'hFFFF_FFF0, 1'b1, 32, rand256(), 7'h3A, 0);
    do_req(32'hFFFF_FFF0, 1'b0, 32, '0, 7'h3B, 0);
    for (int n = 0; n < 14; n++) begin
      a  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFC0 + 32'($urandom_range(0, 63)))
                                       : (32'h0000_0100 + 32'($urandom_range(0, 127)));
      sz = $urandom_range(0, 32);
      do_req(a, 1'($urandom_range(0, 1)), sz, rand256(), 7'($urandom), 0);
    end
    ready_mode = 0;
    repeat (2) @(negedge clk);

`ifdef VDATA_ACCESS_PERF_EN
    chk("perf_req", perf_req_cnt_o, 32'(n_acc));
`else
    chk("perf_zero", {perf_req_cnt_o, perf_split_cnt_o, perf_stall_cnt_o}, 96'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
